// File: rtl/rf_write_arbiter_pkg.sv
// Shared constants for the regfile write-port arbiter.
//   reg_w / mem_w / R_no : register address width, data width, register count
//   RFA_INIT / RFA_RUN   : sequencer state encodings (1 bit)
//   RFA_A / RFA_B        : requester IDs used by the round-robin priority flop
//   rf_we_for()          : write-enable rule for a granted destination register
package rf_write_arbiter_pkg;

  localparam int reg_w = 5;
  localparam int mem_w = 32;
  localparam int R_no  = 32;

  localparam logic [0:0] RFA_INIT = 1'b0;
  localparam logic [0:0] RFA_RUN  = 1'b1;

  localparam logic [0:0] RFA_A = 1'b0;
  localparam logic [0:0] RFA_B = 1'b1;

  // x0 is read-only outside the clear sequence: a granted write to it is
  // acknowledged but never reaches the regfile.
  function automatic logic rf_we_for(input logic [reg_w-1:0] rd);
    return (rd != {reg_w{1'b0}});
  endfunction

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Bundle of the two writeback requester channels and the regfile write port.
//   a_valid/a_rd/a_data -> a_ready : requester A (ALU) channel
//   b_valid/b_rd/b_data -> b_ready : requester B (load) channel
//   rf_rd/rf_we/rf_indata          : regfile write port (from the arbiter)
//   init_done                      : clear sequence complete
// Modport master is the requester/regfile side, slave is the arbiter.
interface rf_write_arbiter_if;
  import rf_write_arbiter_pkg::*;

  logic             a_valid;
  logic [reg_w-1:0] a_rd;
  logic [mem_w-1:0] a_data;
  logic             a_ready;
  logic             b_valid;
  logic [reg_w-1:0] b_rd;
  logic [mem_w-1:0] b_data;
  logic             b_ready;
  logic [reg_w-1:0] rf_rd;
  logic             rf_we;
  logic [mem_w-1:0] rf_indata;
  logic             init_done;

  modport master (
    output a_valid, a_rd, a_data, b_valid, b_rd, b_data,
    input  a_ready, b_ready, rf_rd, rf_we, rf_indata, init_done
  );

  modport slave (
    input  a_valid, a_rd, a_data, b_valid, b_rd, b_data,
    output a_ready, b_ready, rf_rd, rf_we, rf_indata, init_done
  );

endinterface

// File: rtl/rf_write_arbiter_rr_arb2.sv
// Two-request round-robin arbiter.
//   clk, reset : clock, synchronous active-high reset (priority -> A)
//   req[1:0]   : request vector, bit 0 = A, bit 1 = B
//   en         : grant enable; no grant while low
//   gnt[1:0]   : one-hot grant (combinational)
// The priority flop moves to the loser whenever a grant is issued.
module rr_arb2
  import rf_write_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic [0:0] prio_r;
  logic [1:0] gnt_s;

  // Grant selection: a lone request wins outright, a tie goes to prio_r.
  always_comb begin
    gnt_s = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt_s = 2'b01;
        2'b10:   gnt_s = 2'b10;
        2'b11:   gnt_s = (prio_r == RFA_A) ? 2'b01 : 2'b10;
        default: gnt_s = 2'b00;
      endcase
    end else begin
      gnt_s = 2'b00;
    end
  end

  assign gnt = gnt_s;

  // Priority update: the side that did not win goes first next time.
  always_ff @(posedge clk) begin
    if (reset) begin
      prio_r <= RFA_A;
    end else if (gnt_s[0]) begin
      prio_r <= RFA_B;
    end else if (gnt_s[1]) begin
      prio_r <= RFA_A;
    end else begin
      prio_r <= prio_r;
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Sequencer and arbiter for the single regfile write port.
//   clk   : system clock
//   reset : synchronous active-high reset; restarts the clear sequence
//   bus   : requester channels A/B, regfile write port, init_done
// After reset every register is written with zero (rf_rd = 0..R_no-1, one
// per edge); afterwards A and B share the port round-robin. Readys are
// combinational; the regfile port and init_done are registered.
module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  rf_write_arbiter_if.slave   bus
);

  localparam logic [reg_w-1:0] LAST_IDX = reg_w'(R_no - 1);
  localparam logic [reg_w-1:0] IDX_ONE  = {{(reg_w-1){1'b0}}, 1'b1};

  logic [0:0]       state_r;
  logic [reg_w-1:0] idx_r;
  logic [reg_w-1:0] rf_rd_r;
  logic             rf_we_r;
  logic [mem_w-1:0] rf_indata_r;
  logic             init_done_r;
  logic             grant_en_s;
  logic [1:0]       gnt_s;

  // Reset overrides a same-edge handshake, so grants are masked by it too.
  assign grant_en_s = (state_r == RFA_RUN) && !reset;

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   ({bus.b_valid, bus.a_valid}),
    .en    (grant_en_s),
    .gnt   (gnt_s)
  );

  assign bus.a_ready   = gnt_s[0];
  assign bus.b_ready   = gnt_s[1];
  assign bus.rf_rd     = rf_rd_r;
  assign bus.rf_we     = rf_we_r;
  assign bus.rf_indata = rf_indata_r;
  assign bus.init_done = init_done_r;

  // Clear sequencer, state machine and registered regfile write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= RFA_INIT;
      idx_r       <= {reg_w{1'b0}};
      rf_rd_r     <= {reg_w{1'b0}};
      rf_we_r     <= 1'b0;
      rf_indata_r <= {mem_w{1'b0}};
      init_done_r <= 1'b0;
    end else begin
      case (state_r)
        RFA_INIT: begin
          rf_we_r     <= 1'b1;
          rf_rd_r     <= idx_r;
          rf_indata_r <= {mem_w{1'b0}};
          idx_r       <= idx_r + IDX_ONE;
          if (idx_r == LAST_IDX) begin
            state_r     <= RFA_RUN;
            init_done_r <= 1'b1;
          end else begin
            state_r     <= RFA_INIT;
            init_done_r <= init_done_r;
          end
        end
        RFA_RUN: begin
          if (gnt_s[0]) begin
            rf_rd_r     <= bus.a_rd;
            rf_indata_r <= bus.a_data;
            rf_we_r     <= rf_we_for(bus.a_rd);
          end else if (gnt_s[1]) begin
            rf_rd_r     <= bus.b_rd;
            rf_indata_r <= bus.b_data;
            rf_we_r     <= rf_we_for(bus.b_rd);
          end else begin
            // Idle: address/data hold, only the strobe drops.
            rf_we_r <= 1'b0;
          end
        end
        default: begin
          state_r     <= RFA_INIT;
          idx_r       <= {reg_w{1'b0}};
          rf_we_r     <= 1'b0;
          init_done_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
module tb_rf_write_arbiter;
  import rf_write_arbiter_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic do_preload = 1'b0;
  int   checks = 0;
  int   errors = 0;

  rf_write_arbiter_if bus();

  rf_write_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural regfile: write commits on the edge after the port loads.
  logic [mem_w-1:0] rf_mem [R_no];
  always @(posedge clk) begin
    if (do_preload) begin
      for (int k = 0; k < R_no; k++) rf_mem[k] <= $urandom;
    end else if (bus.rf_we === 1'b1) begin
      rf_mem[bus.rf_rd] <= bus.rf_indata;
    end
  end

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] adat;
    logic        bv;
    logic [4:0]  brd;
    logic [31:0] bdat;
    logic        ea;
    logic        eb;
    logic        ewe;
    logic [4:0]  erd;
    logic [31:0] edat;
  } vec_t;

  vec_t vt [21];

  function automatic vec_t mk(logic av, logic [4:0] ard, logic [31:0] adat,
                              logic bv, logic [4:0] brd, logic [31:0] bdat,
                              logic ea, logic eb, logic ewe,
                              logic [4:0] erd, logic [31:0] edat);
    vec_t v;
    v.av = av; v.ard = ard; v.adat = adat;
    v.bv = bv; v.brd = brd; v.bdat = bdat;
    v.ea = ea; v.eb = eb; v.ewe = ewe; v.erd = erd; v.edat = edat;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                       input logic bv, input logic [4:0] brd, input logic [31:0] bdat);
    bus.a_valid = av; bus.a_rd = ard; bus.a_data = adat;
    bus.b_valid = bv; bus.b_rd = brd; bus.b_data = bdat;
  endtask

  initial begin
    // RUN-phase vectors, starting right after the clear (prio = A, rf_rd = 31).
    vt[0]  = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 5'd31, 32'h0);
    vt[1]  = mk(1'b1, 5'd3,  32'h11,       1'b1, 5'd4,  32'h22,       1'b1, 1'b0, 1'b1, 5'd3,  32'h11);
    vt[2]  = mk(1'b1, 5'd3,  32'h11,       1'b1, 5'd4,  32'h22,       1'b0, 1'b1, 1'b1, 5'd4,  32'h22);
    vt[3]  = mk(1'b1, 5'd3,  32'h11,       1'b1, 5'd4,  32'h22,       1'b1, 1'b0, 1'b1, 5'd3,  32'h11);
    vt[4]  = mk(1'b1, 5'd3,  32'h11,       1'b1, 5'd4,  32'h22,       1'b0, 1'b1, 1'b1, 5'd4,  32'h22);
    vt[5]  = mk(1'b1, 5'd3,  32'h11,       1'b1, 5'd4,  32'h22,       1'b1, 1'b0, 1'b1, 5'd3,  32'h11);
    vt[6]  = mk(1'b1, 5'd3,  32'h11,       1'b1, 5'd4,  32'h22,       1'b0, 1'b1, 1'b1, 5'd4,  32'h22);
    vt[7]  = mk(1'b1, 5'd3,  32'h11,       1'b1, 5'd4,  32'h22,       1'b1, 1'b0, 1'b1, 5'd3,  32'h11);
    vt[8]  = mk(1'b1, 5'd3,  32'h11,       1'b1, 5'd4,  32'h22,       1'b0, 1'b1, 1'b1, 5'd4,  32'h22);
    vt[9]  = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 5'd4,  32'h22);
    vt[10] = mk(1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 1'b1, 5'd5,  32'hDEADBEEF);
    vt[11] = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 5'd5,  32'hDEADBEEF);
    vt[12] = mk(1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 5'd0,  32'hFFFFFFFF);
    vt[13] = mk(1'b0, 5'd0,  32'h0,        1'b1, 5'd6,  32'hAB,       1'b0, 1'b1, 1'b1, 5'd6,  32'hAB);
    vt[14] = mk(1'b1, 5'd8,  32'h77,       1'b1, 5'd10, 32'h99,       1'b1, 1'b0, 1'b1, 5'd8,  32'h77);
    vt[15] = mk(1'b0, 5'd0,  32'h0,        1'b1, 5'd10, 32'h99,       1'b0, 1'b1, 1'b1, 5'd10, 32'h99);
    vt[16] = mk(1'b1, 5'd11, 32'h1,        1'b1, 5'd12, 32'h2,        1'b1, 1'b0, 1'b1, 5'd11, 32'h1);
    vt[17] = mk(1'b1, 5'd13, 32'hA1,       1'b1, 5'd12, 32'h2,        1'b0, 1'b1, 1'b1, 5'd12, 32'h2);
    vt[18] = mk(1'b1, 5'd13, 32'hA1,       1'b1, 5'd13, 32'hB2,       1'b1, 1'b0, 1'b1, 5'd13, 32'hA1);
    vt[19] = mk(1'b0, 5'd0,  32'h0,        1'b1, 5'd13, 32'hB2,       1'b0, 1'b1, 1'b1, 5'd13, 32'hB2);
    vt[20] = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 5'd13, 32'hB2);

    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    // Reset/clear: preload random contents, reset for two cycles.
    reset = 1'b1;
    do_preload = 1'b1;
    step();
    do_preload = 1'b0;
    step();
    chk("rst_we", {31'h0, bus.rf_we}, 32'h0);
    chk("rst_rd", {27'h0, bus.rf_rd}, 32'h0);
    chk("rst_data", bus.rf_indata, 32'h0);
    chk("rst_init_done", {31'h0, bus.init_done}, 32'h0);
    chk("rst_a_ready", {31'h0, bus.a_ready}, 32'h0);
    chk("rst_b_ready", {31'h0, bus.b_ready}, 32'h0);
    reset = 1'b0;
    for (int i = 0; i < R_no; i++) begin
      step();
      chk("clr_we", {31'h0, bus.rf_we}, 32'h1);
      chk("clr_rd", {27'h0, bus.rf_rd}, i);
      chk("clr_data", bus.rf_indata, 32'h0);
      chk("clr_init_done", {31'h0, bus.init_done}, (i == R_no - 1) ? 32'h1 : 32'h0);
    end
    step();
    chk("post_clr_we", {31'h0, bus.rf_we}, 32'h0);
    chk("post_clr_init_done", {31'h0, bus.init_done}, 32'h1);
    for (int i = 0; i < R_no; i++) chk("clr_mem", rf_mem[i], 32'h0);

    // Table: readys checked mid-cycle, registered port checked after the edge.
    for (int i = 0; i < 21; i++) begin
      drive(vt[i].av, vt[i].ard, vt[i].adat, vt[i].bv, vt[i].brd, vt[i].bdat);
      #1;
      chk($sformatf("v%0d_a_ready", i), {31'h0, bus.a_ready}, {31'h0, vt[i].ea});
      chk($sformatf("v%0d_b_ready", i), {31'h0, bus.b_ready}, {31'h0, vt[i].eb});
      step();
      chk($sformatf("v%0d_we", i), {31'h0, bus.rf_we}, {31'h0, vt[i].ewe});
      chk($sformatf("v%0d_rd", i), {27'h0, bus.rf_rd}, {27'h0, vt[i].erd});
      chk($sformatf("v%0d_data", i), bus.rf_indata, vt[i].edat);
      if (i == 11) chk("rv_x5_after_2_edges", rf_mem[5], 32'hDEADBEEF);
    end
    chk("mem_x0", rf_mem[0], 32'h0);
    chk("mem_x3", rf_mem[3], 32'h11);
    chk("mem_x4", rf_mem[4], 32'h22);
    chk("mem_x5", rf_mem[5], 32'hDEADBEEF);
    chk("mem_x6", rf_mem[6], 32'hAB);
    chk("mem_x8", rf_mem[8], 32'h77);
    chk("mem_x10", rf_mem[10], 32'h99);
    chk("mem_x11", rf_mem[11], 32'h1);
    chk("mem_x12", rf_mem[12], 32'h2);
    chk("mem_x13_last_wins", rf_mem[13], 32'hB2);

    // Backpressure during INIT: A held valid from the first cycle after reset.
    reset = 1'b1;
    step();
    reset = 1'b0;
    drive(1'b1, 5'd7, 32'h1234, 1'b0, 5'd0, 32'h0);
    for (int i = 0; i < R_no; i++) begin
      #1;
      chk("bp_init_a_ready", {31'h0, bus.a_ready}, 32'h0);
      step();
    end
    chk("bp_first_a_ready", {31'h0, bus.a_ready}, 32'h1);
    step();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #1;
    chk("bp_a_ready_once", {31'h0, bus.a_ready}, 32'h0);
    chk("bp_we", {31'h0, bus.rf_we}, 32'h1);
    chk("bp_rd", {27'h0, bus.rf_rd}, 32'd7);
    step();
    chk("bp_mem_x7", rf_mem[7], 32'h1234);

    // Mid-operation reset: first a normal write of x9, then reset on a B handshake.
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h77);
    #1;
    chk("mr_pre_b_ready", {31'h0, bus.b_ready}, 32'h1);
    step();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    step();
    chk("mr_pre_mem_x9", rf_mem[9], 32'h77);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h55);
    reset = 1'b1;
    #1;
    chk("mr_b_ready_in_reset", {31'h0, bus.b_ready}, 32'h0);
    step();
    chk("mr_we", {31'h0, bus.rf_we}, 32'h0);
    chk("mr_init_done", {31'h0, bus.init_done}, 32'h0);
    chk("mr_rd", {27'h0, bus.rf_rd}, 32'h0);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    reset = 1'b0;
    step();
    chk("mr_restart_rd", {27'h0, bus.rf_rd}, 32'h0);
    chk("mr_restart_we", {31'h0, bus.rf_we}, 32'h1);
    for (int i = 1; i < R_no; i++) step();
    chk("mr_init_done_again", {31'h0, bus.init_done}, 32'h1);
    step();
    chk("mr_mem_x9", rf_mem[9], 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
